// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace buffer: record layout,
// packet framing constants and the header word builder.
package trace_pkg;

    localparam logic [7:0] TRACE_SYNC  = 8'hC3;
    localparam int         TRACE_WORDS = 6;
    localparam logic [2:0] LAST_WIDX   = 3'(TRACE_WORDS - 1);

    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_SEQ_LSB  = 16;
    localparam int HDR_RF_WE    = 15;
    localparam int HDR_DM_WE    = 14;
    localparam int HDR_OVF      = 13;

    typedef struct packed {
        logic [7:0]  seq;
        logic        ovf;
        logic        rf_we;
        logic [4:0]  rf_addr;
        logic [31:0] rf_wdata;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
    } commit_rec_t;

    function automatic logic [31:0] trace_header(input commit_rec_t rec);
        logic [31:0] hdr;
        hdr                                 = '0;
        hdr[HDR_SYNC_LSB +: 8]              = TRACE_SYNC;
        hdr[HDR_SEQ_LSB +: 8]               = rec.seq;
        hdr[HDR_RF_WE]                      = rec.rf_we;
        hdr[HDR_DM_WE]                      = rec.dm_we;
        hdr[HDR_OVF]                        = rec.ovf;
        hdr[4:0]                            = rec.rf_addr;
        return hdr;
    endfunction

endpackage

// File: rtl/trace_rec_fifo.sv
// Synchronous record FIFO with registered occupancy count and a head view.
// Storage is not reset; only pointers and count are.
module trace_rec_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  commit_rec_t              push_rec,
    input  logic                     pop,
    output commit_rec_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    commit_rec_t   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // Full is judged on the start-of-cycle count, so a same-cycle pop never
    // makes room for a push.
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_buf.sv
// Captures per-commit architectural effects of the core and streams them as
// six-word packets; records arriving while the queue is full are counted.
module commit_trace_buf
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cm_valid,
    input  logic [31:0]             cm_pc,
    input  logic [31:0]             cm_instr,
    input  logic                    cm_rf_we,
    input  logic [4:0]              cm_rf_addr,
    input  logic [31:0]             cm_rf_wdata,
    input  logic                    cm_dm_we,
    input  logic [31:0]             cm_dm_addr,
    input  logic [31:0]             cm_dm_wdata,
    output logic                    out_valid,
    output logic [31:0]             out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             drop_cnt
);

    commit_rec_t cap_rec;
    commit_rec_t head;
    logic [7:0]  seq;
    logic        ovf_pend;
    logic [2:0]  widx;
    logic        full;
    logic        push;
    logic        fire;
    logic        pop;

    always_comb begin
        cap_rec          = '0;
        cap_rec.seq      = seq;
        cap_rec.ovf      = ovf_pend;
        cap_rec.rf_we    = cm_rf_we;
        cap_rec.rf_addr  = cm_rf_we ? cm_rf_addr : 5'd0;
        cap_rec.rf_wdata = cm_rf_we ? cm_rf_wdata : 32'd0;
        cap_rec.pc       = cm_pc;
        cap_rec.instr    = cm_instr;
        cap_rec.dm_we    = cm_dm_we;
        cap_rec.dm_addr  = cm_dm_we ? cm_dm_addr : 32'd0;
        cap_rec.dm_wdata = cm_dm_we ? cm_dm_wdata : 32'd0;
    end

    assign push = cm_valid & ~full;
    assign fire = out_valid & out_ready;
    assign pop  = fire & (widx == LAST_WIDX);

    trace_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_rec (cap_rec),
        .pop      (pop),
        .head     (head),
        .count    (level),
        .full     (full)
    );

    // Capture side: sequence numbering covers dropped commits too, so gaps in
    // seq downstream line up with drop_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq      <= 8'd0;
            ovf_pend <= 1'b0;
            drop_cnt <= 16'd0;
        end else if (cm_valid) begin
            seq <= seq + 8'd1;
            if (full) begin
                ovf_pend <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else begin
                ovf_pend <= 1'b0;
            end
        end
    end

    // Serializer: word index advances only on handshake, which keeps the
    // output stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            widx <= 3'd0;
        end else if (fire) begin
            widx <= pop ? 3'd0 : widx + 3'd1;
        end
    end

    assign out_valid = (level != '0);
    assign out_last  = out_valid & (widx == LAST_WIDX);

    always_comb begin
        out_data = 32'd0;
        if (out_valid) begin
            case (widx)
                3'd0:    out_data = trace_header(head);
                3'd1:    out_data = head.pc;
                3'd2:    out_data = head.instr;
                3'd3:    out_data = head.rf_wdata;
                3'd4:    out_data = head.dm_addr;
                3'd5:    out_data = head.dm_wdata;
                default: out_data = 32'd0;
            endcase
        end
    end

endmodule
